// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe controller: cell/winner codes, FSM states
// and the table of the eight winning lines.
package ttt_pkg;

  localparam logic [1:0] EMPTY  = 2'b00;
  localparam logic [1:0] MARK_X = 2'b01;
  localparam logic [1:0] MARK_O = 2'b10;

  localparam logic [1:0] WINNER_NONE = 2'b00;
  localparam logic [1:0] WINNER_P1   = 2'b01;
  localparam logic [1:0] WINNER_P2   = 2'b10;
  localparam logic [1:0] WINNER_DRAW = 2'b11;

  localparam int NUM_CELLS = 9;
  localparam int NUM_LINES = 8;

  typedef enum logic [1:0] {PLAY, CHECK, WIN, DRAW} state_t;

  // Rows, then columns, then the two diagonals; index matches the win_line bit.
  localparam int unsigned LINE_TBL [NUM_LINES][3] = '{
    '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
    '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
    '{0, 4, 8}, '{2, 4, 6}
  };

  function automatic logic [1:0] cell_of(input logic [17:0] b, input int unsigned idx);
    return b[2*idx +: 2];
  endfunction

endpackage

// File: rtl/ttt_win_check.sv
// Combinational line detector: flags every row, column and diagonal fully
// occupied by the given marker.
module ttt_win_check
  import ttt_pkg::*;
(
  input  logic [17:0] board,
  input  logic [1:0]  marker,
  output logic [7:0]  win_line
);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    win_line = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      win_line[i] = (cell_of(board, LINE_TBL[i][0]) == marker) &&
                    (cell_of(board, LINE_TBL[i][1]) == marker) &&
                    (cell_of(board, LINE_TBL[i][2]) == marker);
    end
  end

endmodule

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game sequencer: owns the board, arbitrates turns, detects win/draw.
// Optional turn-forfeit timer enabled with `define MOVE_TIMEOUT_EN.
module ttt_game_ctrl
  import ttt_pkg::*;
`ifdef MOVE_TIMEOUT_EN
#(
  parameter int TIMEOUT_CYCLES = 100000000
)
`endif
(
  input  logic        clk,
  input  logic        clr_n,
  input  logic        enter,
  input  logic [3:0]  cell_sel,
  input  logic        new_game,
  output logic [17:0] board,
  output logic        player_turn,
  output logic [3:0]  move_count,
  output logic        game_over,
  output logic [1:0]  winner,
  output logic [7:0]  win_line,
  output logic        invalid_move,
  output logic        timeout
);

  state_t      state, state_n;
  logic [17:0] board_q, board_n;
  logic        turn_q, turn_n;
  logic [3:0]  count_q, count_n;
  logic [1:0]  winner_q, winner_n;
  logic [7:0]  line_q, line_n;
  logic        invalid_q, invalid_n;
  logic        timeout_q, timeout_n;
  logic        enter_d;
  logic        enter_rise;
  logic [1:0]  mark;
  logic [1:0]  sel_code;
  logic [7:0]  lines_hit;
  logic        tmo_hit;

  assign enter_rise = enter & ~enter_d;
  assign mark       = turn_q ? MARK_O : MARK_X;

  ttt_win_check u_win_check (
    .board    (board_q),
    .marker   (mark),
    .win_line (lines_hit)
  );

  // Contents of the selected cell; out-of-range selections read as occupied.
  always_comb begin
    sel_code = MARK_X;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (cell_sel == 4'(i)) sel_code = cell_of(board_q, i);
    end
  end

`ifdef MOVE_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_q, tmo_n;

  assign tmo_hit = (state == PLAY) && (tmo_q == TMO_LAST);

  always_comb begin
    tmo_n = tmo_q + 1'b1;
    if (new_game || state != PLAY || enter_rise || tmo_hit) tmo_n = '0;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) tmo_q <= '0;
    else        tmo_q <= tmo_n;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    board_n   = board_q;
    turn_n    = turn_q;
    count_n   = count_q;
    winner_n  = winner_q;
    line_n    = line_q;
    invalid_n = 1'b0;
    timeout_n = 1'b0;
    if (new_game) begin
      state_n  = PLAY;
      board_n  = '0;
      turn_n   = 1'b0;
      count_n  = '0;
      winner_n = WINNER_NONE;
      line_n   = '0;
    end else begin
      case (state)
        PLAY: begin
          if (enter_rise) begin
            if (cell_sel <= 4'd8 && sel_code == EMPTY) begin
              for (int i = 0; i < NUM_CELLS; i++) begin
                if (cell_sel == 4'(i)) board_n[2*i +: 2] = mark;
              end
              count_n = count_q + 4'd1;
              state_n = CHECK;
            end else begin
              invalid_n = 1'b1;
            end
          end else if (tmo_hit) begin
            timeout_n = 1'b1;
            turn_n    = ~turn_q;
          end
        end
        CHECK: begin
          if (|lines_hit) begin
            state_n  = WIN;
            winner_n = turn_q ? WINNER_P2 : WINNER_P1;
            line_n   = lines_hit;
          end else if (count_q == 4'd9) begin
            state_n  = DRAW;
            winner_n = WINNER_DRAW;
          end else begin
            turn_n  = ~turn_q;
            state_n = PLAY;
          end
        end
        default: ;  // WIN/DRAW hold everything until restart
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state     <= PLAY;
      board_q   <= '0;
      turn_q    <= 1'b0;
      count_q   <= '0;
      winner_q  <= WINNER_NONE;
      line_q    <= '0;
      invalid_q <= 1'b0;
      timeout_q <= 1'b0;
      enter_d   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state     <= state_n;
      board_q   <= board_n;
      turn_q    <= turn_n;
      count_q   <= count_n;
      winner_q  <= winner_n;
      line_q    <= line_n;
      invalid_q <= invalid_n;
      timeout_q <= timeout_n;
      enter_d   <= enter;
    end
  end

  assign board        = board_q;
  assign player_turn  = turn_q;
  assign move_count   = count_q;
  assign game_over    = (state == WIN) || (state == DRAW);
  assign winner       = winner_q;
  assign win_line     = line_q;
  assign invalid_move = invalid_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Scoreboard bench for ttt_game_ctrl: a per-cycle game model pushes expected
// outputs; an independent monitor pops and compares after each rising edge.
module tb_ttt_game_ctrl;

`ifdef MOVE_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif
  localparam int TC = 8;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        enter = 1'b0;
  logic [3:0]  cell_sel = '0;
  logic        new_game = 1'b0;
  logic [17:0] board;
  logic        player_turn;
  logic [3:0]  move_count;
  logic        game_over;
  logic [1:0]  winner;
  logic [7:0]  win_line;
  logic        invalid_move;
  logic        timeout;

`ifdef MOVE_TIMEOUT_EN
  ttt_game_ctrl #(.TIMEOUT_CYCLES(TC)) dut (
`else
  ttt_game_ctrl dut (
`endif
    .clk          (clk),
    .clr_n        (clr_n),
    .enter        (enter),
    .cell_sel     (cell_sel),
    .new_game     (new_game),
    .board        (board),
    .player_turn  (player_turn),
    .move_count   (move_count),
    .game_over    (game_over),
    .winner       (winner),
    .win_line     (win_line),
    .invalid_move (invalid_move),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [17:0] board;
    logic        turn;
    logic [3:0]  cnt;
    logic        over;
    logic [1:0]  win;
    logic [7:0]  wl;
    logic        inv;
    logic        to;
  } snap_t;

  snap_t exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  // Game model: board as plain integers, 0 empty, 1 X, 2 O.
  int       m_brd[9];
  bit       m_turn, m_over, m_pend, m_en_d, m_inv, m_to;
  int       m_cnt, m_win, m_tmo;
  logic [7:0] m_wl;
  int       lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                            '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 9; i++) m_brd[i] = 0;
    m_turn = 0; m_cnt = 0; m_over = 0; m_win = 0; m_wl = '0; m_pend = 0; m_tmo = 0;
  endfunction

  function automatic void model_reset();
    model_clear();
    m_en_d = 0; m_inv = 0; m_to = 0;
  endfunction

  function automatic void model_step(input bit en, input int sel, input bit ng);
    bit rise;
    int mk;
    rise   = en && !m_en_d;
    m_en_d = en;
    m_inv  = 0;
    m_to   = 0;
    mk     = m_turn ? 2 : 1;
    if (ng) begin
      model_clear();
    end else if (m_over) begin
      // finished game stays frozen
    end else if (m_pend) begin
      m_wl = '0;
      for (int l = 0; l < 8; l++)
        if (m_brd[lines[l][0]] == mk && m_brd[lines[l][1]] == mk && m_brd[lines[l][2]] == mk)
          m_wl[l] = 1'b1;
      if (m_wl != 0) begin
        m_over = 1; m_win = mk;
      end else if (m_cnt == 9) begin
        m_over = 1; m_win = 3;
      end else begin
        m_turn = !m_turn;
      end
      m_pend = 0;
      m_tmo  = 0;
    end else if (rise) begin
      m_tmo = 0;
      if (sel <= 8 && m_brd[sel] == 0) begin
        m_brd[sel] = mk;
        m_cnt++;
        m_pend = 1;
      end else begin
        m_inv = 1;
      end
    end else if (TMO_ON) begin
      if (m_tmo == TC - 1) begin
        m_to = 1; m_turn = !m_turn; m_tmo = 0;
      end else begin
        m_tmo++;
      end
    end
  endfunction

  function automatic snap_t snap();
    snap_t s;
    for (int i = 0; i < 9; i++) s.board[2*i +: 2] = 2'(m_brd[i]);
    s.turn = m_turn;
    s.cnt  = 4'(m_cnt);
    s.over = m_over;
    s.win  = 2'(m_win);
    s.wl   = m_wl;
    s.inv  = m_inv;
    s.to   = m_to;
    return s;
  endfunction

  task automatic cycle(input bit en, input int sel, input bit ng);
    @(negedge clk);
    enter    = en;
    cell_sel = 4'(sel);
    new_game = ng;
    model_step(en, sel, ng);
    exp_q.push_back(snap());
  endtask

  task automatic move(input int sel);
    cycle(1'b1, sel, 1'b0);
    cycle(1'b0, sel, 1'b0);
  endtask

  task automatic hold_reset(input int n);
    @(negedge clk);
    clr_n    = 1'b0;
    enter    = 1'b0;
    new_game = 1'b0;
    model_reset();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(snap());
      @(negedge clk);
    end
    clr_n = 1'b1;
  endtask

  // Monitor: compares every cycle for which an expectation was queued.
  initial begin
    snap_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("board",        32'(board),        32'(e.board));
        check("player_turn",  32'(player_turn),  32'(e.turn));
        check("move_count",   32'(move_count),   32'(e.cnt));
        check("game_over",    32'(game_over),    32'(e.over));
        check("winner",       32'(winner),       32'(e.win));
        check("win_line",     32'(win_line),     32'(e.wl));
        check("invalid_move", 32'(invalid_move), 32'(e.inv));
        check("timeout",      32'(timeout),      32'(e.to));
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int en, sel, ng;
    model_reset();
    hold_reset(2);
    repeat (3) cycle(1'b0, 0, 1'b0);

    // X wins on the top row, then a late request must be ignored
    move(0); move(3); move(1); move(4); move(2);
    cycle(1'b0, 0, 1'b0);
    move(8);
    cycle(1'b0, 0, 1'b1);

    // occupied cell and out-of-range cell rejected
    move(4); move(4); move(9);
    cycle(1'b0, 0, 1'b1);

    // full board without a line
    move(0); move(1); move(2); move(4); move(3); move(5); move(7); move(6); move(8);
    cycle(1'b0, 0, 1'b0);
    cycle(1'b0, 0, 1'b1);
    cycle(1'b0, 0, 1'b0);

    // held enter gives exactly one request
    repeat (10) cycle(1'b1, 0, 1'b0);
    cycle(1'b0, 0, 1'b0);
    cycle(1'b0, 0, 1'b1);

    // restart wins over a simultaneous request
    cycle(1'b1, 5, 1'b1);
    cycle(1'b0, 5, 1'b0);

    // async reset while the move is being evaluated
    move(1); move(7); move(2);
    cycle(1'b1, 0, 1'b0);
    hold_reset(2);
    cycle(1'b0, 0, 1'b0);

    // idle play (forfeit when the timer is built), then request on the forfeit cycle
    hold_reset(1);
    repeat (10) cycle(1'b0, 0, 1'b0);
    hold_reset(1);
    repeat (7) cycle(1'b0, 0, 1'b0);
    cycle(1'b1, 4, 1'b0);
    cycle(1'b0, 4, 1'b0);

    // random play
    for (int i = 0; i < 400; i++) begin
      en  = int'($urandom_range(0, 1));
      sel = ($urandom_range(0, 7) == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8));
      ng  = ($urandom_range(0, 40) == 0) ? 1 : 0;
      cycle(en[0], sel, ng[0]);
    end
    cycle(1'b0, 0, 1'b0);

    @(negedge clk);
    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
